// File: rtl/mips_mem_responder.sv
// ============================================================================
//  Module      : mips_mem_responder
//  Description : Word-addressed memory beside the MIPS core. Serves fetches,
//                loads and stores, and is preloaded through a valid/ready
//                loader port before the core is released via mem_ready.
//                Optional macro ACCESS_CNT_EN adds store and fetch counters.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module mips_mem_responder #(
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter int          AW        = 19,
    parameter logic [31:0] OOR_DATA  = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr_addr,
    output logic [31:0] instr_in,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_out,
    input  logic        data_rd_wr,
    output logic [31:0] data_in,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [31:0] ld_addr,
    input  logic [31:0] ld_data,
    input  logic        ld_last,
    output logic        mem_ready,
    output logic        err_misalign,
    output logic        err_range,
    output logic [31:0] wr_cnt,
    output logic [31:0] fetch_cnt
);

    localparam int DEPTH = 1 << AW;

    typedef enum logic [0:0] {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    function automatic logic in_window(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - BASE_ADDR;
        return (off >> (AW + 2)) == 32'd0;
    endfunction

    function automatic logic [AW-1:0] word_idx(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - BASE_ADDR;
        return off[AW+1:2];
    endfunction

    logic [31:0] mem [DEPTH];

    state_t      state_q, state_d;
    logic        ld_ready_q, ld_ready_d;
    logic        mem_ready_q, mem_ready_d;
    logic [31:0] instr_in_q, instr_in_d;
    logic        err_misalign_q, err_misalign_d;
    logic        err_range_q, err_range_d;

    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [31:0]   mem_wdata;

    logic fetch_win;
    logic data_win;
    logic data_aligned;
    logic store_ok;

    assign fetch_win    = in_window(instr_addr);
    assign data_win     = in_window(data_addr);
    assign data_aligned = (data_addr[1:0] == 2'b00);
    assign store_ok     = (state_q == ST_RUN) && !data_rd_wr && data_aligned && data_win;

    // Loads bypass the FSM: the core may read at any time, including during LOAD.
    always_comb begin
        data_in = 32'd0;
        if (data_rd_wr) begin
            data_in = data_win ? mem[word_idx(data_addr)] : OOR_DATA;
        end
    end

    always_comb begin
        state_d        = state_q;
        ld_ready_d     = ld_ready_q;
        mem_ready_d    = mem_ready_q;
        instr_in_d     = instr_in_q;
        err_misalign_d = err_misalign_q;
        err_range_d    = err_range_q;
        mem_we         = 1'b0;
        mem_waddr      = word_idx(ld_addr);
        mem_wdata      = ld_data;

        case (state_q)
            ST_LOAD: begin
                ld_ready_d  = 1'b1;
                mem_ready_d = 1'b0;
                if (ld_valid && ld_ready_q) begin
                    if (in_window(ld_addr)) begin
                        mem_we = 1'b1;
                    end else begin
                        err_range_d = 1'b1;
                    end
                    if (ld_last) begin
                        state_d     = ST_RUN;
                        ld_ready_d  = 1'b0;
                        mem_ready_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                ld_ready_d  = 1'b0;
                mem_ready_d = 1'b1;
                // Fetch samples the array before this edge's store lands.
                if (fetch_win) begin
                    instr_in_d = mem[word_idx(instr_addr)];
                end else begin
                    instr_in_d  = OOR_DATA;
                    err_range_d = 1'b1;
                end
                if (!data_rd_wr) begin
                    if (!data_aligned) begin
                        err_misalign_d = 1'b1;
                    end
                    if (!data_win) begin
                        err_range_d = 1'b1;
                    end
                end
                if (store_ok) begin
                    mem_we    = 1'b1;
                    mem_waddr = word_idx(data_addr);
                    mem_wdata = data_out;
                end
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_LOAD;
            ld_ready_q     <= 1'b0;
            mem_ready_q    <= 1'b0;
            instr_in_q     <= 32'd0;
            err_misalign_q <= 1'b0;
            err_range_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            ld_ready_q     <= ld_ready_d;
            mem_ready_q    <= mem_ready_d;
            instr_in_q     <= instr_in_d;
            err_misalign_q <= err_misalign_d;
            err_range_q    <= err_range_d;
        end
    end

    // Array contents survive reset so a partial load is kept.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign instr_in     = instr_in_q;
    assign ld_ready     = ld_ready_q;
    assign mem_ready    = mem_ready_q;
    assign err_misalign = err_misalign_q;
    assign err_range    = err_range_q;

`ifdef ACCESS_CNT_EN
    logic [31:0] wr_cnt_q, wr_cnt_d;
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] prev_addr_q, prev_addr_d;
    logic        ran_q, ran_d;
    logic        fetch_new;

    // ran_q marks that the previous edge was already in RUN.
    assign fetch_new = (state_q == ST_RUN) && (!ran_q || (instr_addr != prev_addr_q));

    always_comb begin
        wr_cnt_d    = wr_cnt_q + {31'd0, store_ok};
        fetch_cnt_d = fetch_cnt_q + {31'd0, fetch_new};
        prev_addr_d = instr_addr;
        ran_d       = (state_q == ST_RUN);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_cnt_q    <= 32'd0;
            fetch_cnt_q <= 32'd0;
            prev_addr_q <= 32'd0;
            ran_q       <= 1'b0;
        end else begin
            wr_cnt_q    <= wr_cnt_d;
            fetch_cnt_q <= fetch_cnt_d;
            prev_addr_q <= prev_addr_d;
            ran_q       <= ran_d;
        end
    end

    assign wr_cnt    = wr_cnt_q;
    assign fetch_cnt = fetch_cnt_q;
`else
    assign wr_cnt    = 32'd0;
    assign fetch_cnt = 32'd0;
`endif

endmodule

`default_nettype wire
